// File: rtl/sp_issue.sv
// Issue/writeback sequencer for one SP lane: reads per-thread operands,
// issues them under ena/ack and writes the SP result back, thread by thread.
module sp_issue #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        Resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_opcode,
  input  logic [2:0]  req_modifier,
  input  logic        req_Si,
  input  logic [2:0]  req_Sp,
  input  logic [2:0]  req_Dp,
  input  logic [8:0]  req_addr_d,
  input  logic [7:0]  req_thread_cnt,
  output logic        rf_rd_en,
  output logic [7:0]  rf_rd_thread,
  input  logic [31:0] rf_rs_a,
  input  logic [31:0] rf_rs_b,
  input  logic [31:0] rf_rs_c,
  output logic        ena,
  output logic [31:0] rs_a,
  output logic [31:0] rs_b,
  output logic [31:0] rs_c,
  output logic [8:0]  addr_d,
  output logic [2:0]  Sp,
  output logic [2:0]  Dp,
  output logic [2:0]  modifier,
  output logic        Si,
  output logic [5:0]  opcode,
  output logic [7:0]  thread_cnt,
  input  logic        ack,
  input  logic [31:0] out,
  input  logic [8:0]  des_addr,
  input  logic [2:0]  des_pre,
  output logic        wb_valid,
  output logic [7:0]  wb_thread,
  output logic [8:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic [2:0]  wb_pre,
  output logic        done,
  output logic        err
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TO_V = WW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CAPT, S_ISSUE, S_WB, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [2:0]  mod_q, mod_d;
  logic        si_q, si_d;
  logic [2:0]  sp_q, sp_d;
  logic [2:0]  dp_q, dp_d;
  logic [8:0]  ad_q, ad_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  tidx_q, tidx_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] c_q, c_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [31:0] res_q, res_d;
  logic [8:0]  des_q, des_d;
  logic [2:0]  pre_q, pre_d;
  logic        err_q, err_d;

  logic [WW-1:0] wait_inc;
  logic [7:0]    last;

  assign wait_inc = wait_q + WW'(1);
  assign last     = cnt_q - 8'd1;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    mod_d   = mod_q;
    si_d    = si_q;
    sp_d    = sp_q;
    dp_d    = dp_q;
    ad_d    = ad_q;
    cnt_d   = cnt_q;
    tidx_d  = tidx_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    wait_d  = wait_q;
    res_d   = res_q;
    des_d   = des_q;
    pre_d   = pre_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d   = req_opcode;
          mod_d  = req_modifier;
          si_d   = req_Si;
          sp_d   = req_Sp;
          dp_d   = req_Dp;
          ad_d   = req_addr_d;
          cnt_d  = req_thread_cnt;
          tidx_d = 8'd0;
          state_d = (req_thread_cnt == 8'd0) ? S_DONE : S_READ;
        end
      end
      S_READ: state_d = S_CAPT;
      S_CAPT: begin
        a_d     = rf_rs_a;
        b_d     = rf_rs_b;
        c_d     = rf_rs_c;
        wait_d  = '0;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        // ack takes priority over a timeout in the same cycle
        if (ack) begin
          res_d   = out;
          des_d   = des_addr;
          pre_d   = des_pre;
          state_d = S_WB;
        end else if (wait_inc == TO_V) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_WB: begin
        if (tidx_q == last) begin
          state_d = S_DONE;
        end else begin
          tidx_d  = tidx_q + 8'd1;
          state_d = S_READ;
        end
      end
      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      mod_q   <= '0;
      si_q    <= 1'b0;
      sp_q    <= '0;
      dp_q    <= '0;
      ad_q    <= '0;
      cnt_q   <= '0;
      tidx_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      wait_q  <= '0;
      res_q   <= '0;
      des_q   <= '0;
      pre_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mod_q   <= mod_d;
      si_q    <= si_d;
      sp_q    <= sp_d;
      dp_q    <= dp_d;
      ad_q    <= ad_d;
      cnt_q   <= cnt_d;
      tidx_q  <= tidx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      wait_q  <= wait_d;
      res_q   <= res_d;
      des_q   <= des_d;
      pre_q   <= pre_d;
      err_q   <= err_d;
    end
  end

  assign req_ready    = (state_q == S_IDLE);
  assign rf_rd_en     = (state_q == S_READ);
  assign rf_rd_thread = tidx_q;
  assign ena          = (state_q == S_ISSUE);
  assign rs_a         = a_q;
  assign rs_b         = b_q;
  assign rs_c         = c_q;
  assign addr_d       = ad_q;
  assign Sp           = sp_q;
  assign Dp           = dp_q;
  assign modifier     = mod_q;
  assign Si           = si_q;
  assign opcode       = op_q;
  assign thread_cnt   = tidx_q;
  assign wb_valid     = (state_q == S_WB);
  assign wb_thread    = tidx_q;
  assign wb_addr      = des_q;
  assign wb_data      = res_q;
  assign wb_pre       = pre_q;
  assign done         = (state_q == S_DONE);
  assign err          = (state_q == S_DONE) && err_q;

endmodule

// File: doc/sp_issue.md
# sp_issue

Issue/writeback sequencer that drives one `sp` streaming-processor lane from the warp scheduler. It accepts one decoded warp instruction and walks threads 0..thread_cnt-1. For each thread it reads operands from the per-thread register file, presents them to the SP under an ena/ack handshake, and writes the SP result back. It is the initiating end of the SP operand interface: it owns `ena` and the operand buses, and consumes `ack`, `out`, `des_addr` and `des_pre`.

## Interface
Parameters:
- TIMEOUT, 64: max cycles in ISSUE without ack before abort (≥2).

Ports:
- clk  in  1  single clock; everything on the rising edge.
- Resetn  in  1  reset, synchronous, active-low.
- req_valid  in  1  instruction offered by scheduler.
- req_ready  out  1  high only in IDLE.
- req_opcode  in  6; req_modifier  in  3; req_Si  in  1; req_Sp  in  3; req_Dp  in  3; req_addr_d  in  9: instruction fields.
- req_thread_cnt  in  8  active threads; 0 = no-op.
- rf_rd_en  out  1  register-file read strobe.
- rf_rd_thread  out  8  thread index being read.
- rf_rs_a, rf_rs_b, rf_rs_c  in  32 each  read data, valid exactly 1 cycle after rf_rd_en.
- ena  out  1  operand valid to SP.
- rs_a, rs_b, rs_c  out  32 each; addr_d  out  9; Sp, Dp, modifier  out  3 each; Si  out  1; opcode  out  6; thread_cnt  out  8 (current thread index): SP operand bus.
- ack  in  1  SP result valid; out  in  32; des_addr  in  9; des_pre  in  3: SP result bus.
- wb_valid  out  1; wb_thread  out  8; wb_addr  out  9; wb_data  out  32; wb_pre  out  3: writeback port.
- done  out  1  one-cycle pulse at instruction end.
- err  out  1  one-cycle pulse, coincident with done, on timeout abort.

## Operation
- FSM states: IDLE, READ, CAPT, ISSUE, WB, DONE.
- IDLE: req_ready=1. On req_valid, latch all req_* fields and set tidx=0.
  - If req_thread_cnt=0, go to DONE.
  - Otherwise go to READ.
- READ: rf_rd_en=1, rf_rd_thread=tidx. Go to CAPT.
- CAPT: register rf_rs_a/b/c into the operand latches. Go to ISSUE.
- ISSUE: ena=1. Operand bus driven from the latches and held stable for the whole state. thread_cnt output = tidx.
  - On ack=1: latch out/des_addr/des_pre and go to WB.
  - Else, when the wait counter reaches TIMEOUT: go to DONE with the error flag set.
- WB: wb_valid=1, wb_thread=tidx, wb_addr=latched des_addr, wb_data=latched out, wb_pre=latched des_pre.
  - If tidx == cnt-1, go to DONE.
  - Else tidx++ and go to READ.
- DONE: done=1, and err=error flag. Clear the flag. Go to IDLE.
- Width rules:
  - tidx is 8-bit, compared against cnt-1 computed in 8 bits. cnt=255 reaches tidx=254 with no wrap.
  - The wait counter is $clog2(TIMEOUT+1) bits and is cleared on every ISSUE entry.
- ack outside ISSUE is ignored. SP results are never written back without a preceding ena.
- req_valid outside IDLE is ignored; a new instruction is not latched until IDLE.

## Timing
- Reset (Resetn=0 at an edge), including mid-instruction: next state is IDLE and all registers clear. Every output is 0 except req_ready, which is 1.
- All outputs are registered, or decoded from the registered state only. No combinational path from ack or req_valid to any output.
- Accept at edge T0 (IDLE, req_valid=1): READ in cycle T0+1, CAPT in T0+2, ISSUE (ena=1) from T0+3.
- ack sampled high in ISSUE at cycle Tk: ena=0 and wb_valid=1 in Tk+1.
- Per-thread minimum is 4 cycles (READ, CAPT, ISSUE with ack in its first cycle, WB).
- N threads with immediate ack: done in cycle T0+1+4N.
- No-op (cnt=0): done in T0+1, and req_ready again in T0+2.
- Timeout: ena stays high for exactly TIMEOUT cycles. done=err=1 in the following cycle. No wb_valid for the failed thread; earlier threads' writebacks stand.
- ack arriving in the same cycle the counter hits TIMEOUT: ack wins and the thread completes normally.

## Test plan
- Reset: hold Resetn=0 for 3 cycles with random inputs -> req_ready=1 and every other output 0. Then assert reset during ISSUE -> ena=0 and IDLE on the next cycle.
- Single thread: cnt=1, rf returns a=5, b=7, c=0, SP acks in the first ISSUE cycle with out=12, des_addr=9'h1A, des_pre=3 -> ena held with rs_a=5 and rs_b=7; wb_valid once with wb_data=12 and wb_addr=0x1A; done at T0+5.
- Multi-thread with variable ack delay: cnt=4, acks after 0/3/1/5 wait cycles -> wb_thread sequence 0,1,2,3; rf_rd_thread matches; operands stable while ena is high; done exactly once.
- No-op: cnt=0 -> no rf_rd_en, no ena, no wb_valid; done at T0+1.
- Timeout: TIMEOUT=8, SP never acks on thread 2 of 4 -> ena high for 8 cycles, then done=err=1; only threads 0 and 1 written back.
- Boundary: cnt=255 with immediate acks -> 255 writebacks, last wb_thread=254, done at T0+1021. Also a stray ack while in IDLE/READ produces no writeback.
